// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem requests,
// IF/ID register with immediate-format pre-decode, stall/redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [2:0]  id_imm_ctrl
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inflight_pc, inflight_n;
    logic        drop, drop_n;
    logic [31:0] hold_instr, hold_pc;
    logic        load, load_hold, hold_wr;
    logic        id_free;
    logic [31:0] ld_instr, ld_pc;

    // Immediate format from the major opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_fmt(input logic [31:0] instr);
        case (instr[6:0])
            7'b0100011:             imm_fmt = 3'd1;
            7'b1100011:             imm_fmt = 3'd2;
            7'b1101111:             imm_fmt = 3'd3;
            7'b0110111, 7'b0010111: imm_fmt = 3'd4;
            default:                imm_fmt = 3'd0;
        endcase
    endfunction

    // Request only in REQ; gated by reset so nothing is offered while held in reset.
    assign imem_req_valid = rst_n && (state == REQ);
    assign imem_addr      = pc;

    assign id_free  = !id_valid || !stall;
    assign ld_instr = load_hold ? hold_instr : imem_rsp_data;
    assign ld_pc    = load_hold ? hold_pc    : inflight_pc;

    // Next-state, PC and IF/ID load control; redirect overrides everything else.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inflight_n = inflight_pc;
        drop_n     = drop;
        load       = 1'b0;
        load_hold  = 1'b0;
        hold_wr    = 1'b0;
        case (state)
            REQ: begin
                if (imem_req_ready) begin
                    state_n    = WAIT;
                    inflight_n = pc;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_n = REQ;
                    if (drop) begin
                        drop_n = 1'b0;
                    end else begin
                        pc_n = inflight_pc + 32'd4;
                        if (id_free) begin
                            load = 1'b1;
                        end else begin
                            hold_wr = 1'b1;
                            state_n = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    load      = 1'b1;
                    load_hold = 1'b1;
                    state_n   = REQ;
                end
            end
            default: state_n = REQ;
        endcase
        if (redirect_valid) begin
            pc_n    = {redirect_pc[31:2], 2'b00};
            load    = 1'b0;
            hold_wr = 1'b0;
            case (state)
                // A request accepted this cycle is stale: its response must be dropped.
                REQ:  drop_n = imem_req_ready;
                WAIT: begin
                    state_n = imem_rsp_valid ? REQ : WAIT;
                    drop_n  = !imem_rsp_valid;
                end
                default: begin
                    state_n = REQ;
                    drop_n  = 1'b0;
                end
            endcase
        end
    end

    // FSM, PC and in-flight tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            drop        <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            inflight_pc <= inflight_n;
            drop        <= drop_n;
        end
    end

    // Hold buffer: parks a returned word while decode is stalled on a live one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_instr <= 32'h0000_0013;
            hold_pc    <= 32'h0;
        end else if (hold_wr) begin
            hold_instr <= imem_rsp_data;
            hold_pc    <= inflight_pc;
        end
    end

    // IF/ID register: load, hold on stall, or bubble; redirect kills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= 32'h0000_0013;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'h0;
            id_imm_ctrl <= 3'd0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_instr    <= ld_instr;
            id_pc       <= ld_pc;
            id_pc_plus4 <= ld_pc + 32'd4;
            id_imm_ctrl <= imm_fmt(ld_instr);
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable imem model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [2:0]  id_imm_ctrl;

    int tests = 0;
    int fails = 0;

    logic [31:0] words [8];
    int          mem_lat = 0;
    logic        pend = 1'b0;
    logic [31:0] pa = 32'h0;
    int          cnt = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_imm_ctrl(id_imm_ctrl)
    );

    always #5 clk = ~clk;

    // Memory: accepted request answered mem_lat cycles after the next edge.
    always @(posedge clk) begin
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend = 1'b1;
            pa   = a;
            cnt  = mem_lat;
        end
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = words[pa[4:2]];
                pend           = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b1;
        mem_lat = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) words[i] = 32'h0050_0093;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL rst_addr got %h exp 00000100", imem_addr); end
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        tests++; if (id_instr !== 32'h13) begin fails++; $display("FAIL rst_id_instr got %h exp 00000013", id_instr); end
        tests++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL rst_id_pc got %h/%h exp 0/0", id_pc, id_pc_plus4); end
        tests++; if (id_imm_ctrl !== 3'd0) begin fails++; $display("FAIL rst_imm got %0d exp 0", id_imm_ctrl); end
        rst_n = 1'b1;
        #1;
        tests++; if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL rel_req_valid got %b exp 1", imem_req_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            epc = 32'h100 + 32'(4 * (k / 2));
            tests++; if (id_valid !== (k % 2 == 1)) begin fails++; $display("FAIL stream_valid k=%0d got %b", k, id_valid); end
            tests++; if (imem_req_valid !== (k % 2 == 1)) begin fails++; $display("FAIL stream_req k=%0d got %b", k, imem_req_valid); end
            if (k % 2 == 1) begin
                tests++; if (id_pc !== epc || id_pc_plus4 !== epc + 32'd4) begin fails++; $display("FAIL stream_pc k=%0d got %h/%h exp %h", k, id_pc, id_pc_plus4, epc); end
                tests++; if (id_instr !== 32'h0050_0093 || id_imm_ctrl !== 3'd0) begin fails++; $display("FAIL stream_instr got %h/%0d exp 00500093/0", id_instr, id_imm_ctrl); end
                tests++; if (imem_addr !== epc + 32'd4) begin fails++; $display("FAIL stream_addr k=%0d got %h exp %h", k, imem_addr, epc + 32'd4); end
            end
        end
    endtask

    task automatic test_opcodes();
        logic [31:0] w [5];
        logic [2:0]  e [5];
        w[0] = 32'h0011_2023; e[0] = 3'd1;
        w[1] = 32'hFE00_0EE3; e[1] = 3'd2;
        w[2] = 32'h0000_006F; e[2] = 3'd3;
        w[3] = 32'h0000_02B7; e[3] = 3'd4;
        w[4] = 32'h0000_0033; e[4] = 3'd0;
        for (int i = 0; i < 5; i++) words[i] = w[i];
        do_reset();
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(negedge clk);
            tests++; if (id_valid !== 1'b1 || id_instr !== w[i]) begin fails++; $display("FAIL opc_instr i=%0d got %b/%h exp 1/%h", i, id_valid, id_instr, w[i]); end
            tests++; if (id_imm_ctrl !== e[i]) begin fails++; $display("FAIL opc_imm i=%0d got %0d exp %0d", i, id_imm_ctrl, e[i]); end
        end
    endtask

    task automatic test_stall_hold();
        words[0] = 32'h0010_0093;
        words[1] = 32'h0020_0113;
        words[2] = 32'h0030_0193;
        do_reset();
        repeat (2) @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_instr !== 32'h0010_0093) begin fails++; $display("FAIL stall_first got %b/%h exp 1/00100093", id_valid, id_instr); end
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++; if (id_valid !== 1'b1 || id_instr !== 32'h0010_0093 || id_pc !== 32'h100) begin fails++; $display("FAIL stall_keep k=%0d got %b/%h/%h", k, id_valid, id_instr, id_pc); end
            tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL stall_noreq k=%0d got %b exp 0", k, imem_req_valid); end
        end
        stall = 1'b0;
        @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_instr !== 32'h0020_0113 || id_pc !== 32'h104) begin fails++; $display("FAIL stall_release got %b/%h/%h exp 1/00200113/104", id_valid, id_instr, id_pc); end
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h108) begin fails++; $display("FAIL stall_resume got %b/%h exp 1/108", imem_req_valid, imem_addr); end
        repeat (2) @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_instr !== 32'h0030_0193 || id_pc !== 32'h108) begin fails++; $display("FAIL stall_next got %b/%h/%h exp 1/00300193/108", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        mem_lat = 2;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_wait got %b/%b exp 0/0", id_valid, imem_req_valid); end
        repeat (2) @(negedge clk);
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL redir_drop got %b exp 0", id_valid); end
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL redir_addr got %b/%h exp 1/200", imem_req_valid, imem_addr); end
        mem_lat = 0;
        repeat (2) @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin fails++; $display("FAIL redir_target got %b/%h exp 1/200", id_valid, id_pc); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        repeat (2) @(negedge clk);
        tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL rs_pre got %b exp 1", id_valid); end
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rs_kill got %b exp 0", id_valid); end
        stall = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        tests++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin fails++; $display("FAIL rs_after got %b/%b/%h exp 0/1/300", id_valid, imem_req_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        words[7] = 32'h0000_0013;
        do_reset();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got %b/%h exp 1/fffffffc", imem_req_valid, imem_addr); end
        repeat (2) @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_id got %b/%h/%h exp 1/fffffffc/0", id_valid, id_pc, id_pc_plus4); end
        tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next got %b/%h exp 1/0", imem_req_valid, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        words[0] = 32'h0011_2023;
        words[1] = 32'h0000_006F;
        do_reset();
        repeat (2) @(negedge clk);
        stall = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_imm_ctrl !== 3'd1) begin fails++; $display("FAIL mr_pre got %b/%0d exp 1/1", id_valid, id_imm_ctrl); end
        rst_n = 1'b0;
        stall = 1'b0;
        #1;
        tests++; if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_imm_ctrl !== 3'd0) begin fails++; $display("FAIL mr_id got %b/%h/%0d exp 0/00000013/0", id_valid, id_instr, id_imm_ctrl); end
        tests++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin fails++; $display("FAIL mr_pc got %h/%h exp 0/0", id_pc, id_pc_plus4); end
        tests++; if (imem_req_valid !== 1'b0 || imem_addr !== 32'h100) begin fails++; $display("FAIL mr_req got %b/%h exp 0/100", imem_req_valid, imem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL mr_stale got %b/%b exp 0/0", id_valid, imem_req_valid); end
        @(negedge clk);
        tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL mr_wait got %b exp 0", id_valid); end
        @(negedge clk);
        tests++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h0011_2023) begin fails++; $display("FAIL mr_first got %b/%h/%h exp 1/100/00112023", id_valid, id_pc, id_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_opcodes();
        test_stall_hold();
        test_redirect_inflight();
        test_redirect_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
